// File: rtl/prio_scan_encoder.sv
// rtl/prio_scan_encoder.sv - request-vector to serial set-bit index stream encoder
//
// Purpose:
//   Captures an N-bit request vector and streams out the binary index of
//   every set bit, one beat per clock, over a valid/ready handshake. The
//   final beat of a vector is flagged with out_last. An all-zero vector
//   produces a single-cycle empty_pulse and no output beat.
//
// Configuration macro:
//   PRIO_SCAN_MSB_FIRST_EN  undefined: lowest set bit first (default)
//                           defined:   highest set bit first
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   enable       in   1      permits capture of new vectors
//   in_valid     in   1      in_data is valid
//   in_ready     out  1      vector can be captured this cycle
//   in_data      in   WIDTH  request vector
//   out_valid    out  1      out_index/out_last valid
//   out_ready    in   1      consumer accepts the current beat
//   out_index    out  IDX_W  index of the current set bit
//   out_last     out  1      current beat is the final set bit
//   empty_pulse  out  1      accepted vector was all-zero (one cycle)

module prio_scan_encoder #(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             empty_pulse
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] residual_q, residual_d;
  logic             empty_q, empty_d;

  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_onehot;
  logic             single_bit;
  logic             out_fire;
  logic             in_fire;

  // Pick the bit to present this beat. The loop runs toward the preferred
  // end so that the last match written is the one that wins.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
`ifdef PRIO_SCAN_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (residual_q[i]) begin
        sel_idx       = IDX_W'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (residual_q[i]) begin
        sel_idx       = IDX_W'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
`endif
  end

  // Exactly one bit left: nonzero and clearing the lowest set bit leaves zero.
  assign single_bit = (residual_q != '0) &&
                      ((residual_q & (residual_q - WIDTH'(1))) == '0);

  assign out_valid   = (state_q == ST_SCAN);
  assign out_index   = sel_idx;
  assign out_last    = single_bit;
  assign empty_pulse = empty_q;

  assign out_fire = out_valid & out_ready;

  // A new vector may slip in on the cycle the final beat is consumed, which
  // keeps back-to-back vectors bubble-free.
  assign in_ready = enable & ~rst & ((state_q == ST_IDLE) | (out_fire & out_last));
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    empty_d    = 1'b0;

    if (out_fire) begin
      residual_d = residual_q & ~sel_onehot;
      if (out_last) begin
        state_d = ST_IDLE;
      end
    end

    // Capture overrides the drain result: it only happens when idle or on
    // the final beat, where the residual is empty anyway.
    if (in_fire) begin
      residual_d = in_data;
      if (in_data == '0) begin
        state_d = ST_IDLE;
        empty_d = 1'b1;
      end else begin
        state_d = ST_SCAN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      residual_q <= '0;
      empty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      empty_q    <= empty_d;
    end
  end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// tb/tb_prio_scan_encoder.sv - scoreboard bench for prio_scan_encoder

module tb_prio_scan_encoder;

  localparam int W  = 16;
  localparam int IW = 4;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          empty_pulse;

  prio_scan_encoder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_last    (out_last),
    .empty_pulse (empty_pulse)
  );

  always #5 clk = ~clk;

  beat_t sb[$];
  int    beat_cyc[$];
  int    exp_empty = 0;
  int    n_checks  = 0;
  int    n_pass    = 0;
  int    cyc       = 0;
  bit    rand_ready = 0;
  bit    ready_force = 0;
  bit    rand_en = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: list every set bit position in scan order; last flag on the final one.
  task automatic push_model(input logic [W-1:0] v);
    int idxs[$];
    for (int i = 0; i < W; i++) if (v[i]) idxs.push_back(i);
`ifdef PRIO_SCAN_MSB_FIRST_EN
    idxs.reverse();
`endif
    if (idxs.size() == 0) exp_empty++;
    for (int k = 0; k < idxs.size(); k++) begin
      beat_t b;
      b.idx  = IW'(idxs[k]);
      b.last = (k == idxs.size() - 1);
      sb.push_back(b);
    end
  endtask

  // Consumer ready driver (single writer of out_ready).
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? ($urandom % 10 < 7) : ready_force;
    end
  end

  // Monitor: pops expected beats on every accepted output beat.
  initial begin
    beat_t b;
    bit    stall_prev = 0;
    bit    rst_prev = 1;
    logic [IW-1:0] pidx = '0;
    logic  plast = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (stall_prev && !rst_prev)
          chk(out_valid && out_index == pidx && out_last == plast, "stall_hold",
              int'(out_index), int'(pidx));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk(0, "unexpected_beat", int'(out_index), -1);
          end else begin
            b = sb.pop_front();
            chk(out_index == b.idx, "out_index", int'(out_index), int'(b.idx));
            chk(out_last == b.last, "out_last", int'(out_last), int'(b.last));
            beat_cyc.push_back(cyc);
          end
        end
        if (empty_pulse) begin
          chk(exp_empty > 0, "empty_pulse_unexpected", 1, 0);
          if (exp_empty > 0) exp_empty--;
        end
      end
      stall_prev = out_valid && !out_ready;
      pidx       = out_index;
      plast      = out_last;
      rst_prev   = rst;
    end
  end

  // Present v until accepted; returns at posedge+1 just after the capture edge.
  task automatic send_vec(input logic [W-1:0] v);
    int t = 0;
    in_valid = 1'b1;
    in_data  = v;
    if (rand_en) enable = ($urandom % 4 != 0);
    forever begin
      @(negedge clk);
      if (!enable) chk(!in_ready, "in_ready_disabled", int'(in_ready), 0);
      if (in_ready || t >= 300) break;
      t++;
      @(posedge clk);
      #1;
      if (rand_en) enable = ($urandom % 4 != 0);
    end
    chk(t < 300, "accept_timeout", t, 300);
    if (in_ready) push_model(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk(t < 600, "drain_timeout", t, 600);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [W-1:0] v;

    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(!in_ready, "in_ready_in_reset", int'(in_ready), 0);
    chk(!out_valid && out_index == 0 && !out_last && !empty_pulse, "reset_outputs",
        int'({out_valid, out_index, out_last, empty_pulse}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(in_ready, "in_ready_idle", int'(in_ready), 1);
    @(posedge clk); #1;

    // Walking one with one-cycle latency.
    ready_force = 1;
    for (int i = 0; i < W; i++) begin
      send_vec(W'(1) << i);
      @(negedge clk);
      chk(out_valid, "latency_1clk", int'(out_valid), 1);
      drain();
    end

    // Multi-bit and all-ones.
    send_vec(16'h8421); drain();
    send_vec(16'hFFFF); drain();

    // Backpressure.
    ready_force = 0;
    @(posedge clk); #1;
    send_vec(16'h0006);
    repeat (3) begin
      @(negedge clk);
      chk(!in_ready, "in_ready_during_scan", int'(in_ready), 0);
      chk(out_valid && out_index == 1, "bp_hold_index", int'(out_index), 1);
    end
    @(posedge clk); #1;
    ready_force = 1;
    drain();

    // Enable low blocks capture; zero vector gives only empty_pulse.
    enable = 1'b0; in_valid = 1'b1; in_data = 16'h0001;
    repeat (3) begin
      @(negedge clk);
      chk(!in_ready, "in_ready_enable_low", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; enable = 1'b1;
    send_vec(16'h0000);
    @(negedge clk);
    chk(empty_pulse && !out_valid, "empty_pulse_zero", int'({empty_pulse, out_valid}), 2);
    @(negedge clk);
    chk(!empty_pulse && !out_valid, "empty_pulse_one_cycle", int'({empty_pulse, out_valid}), 0);
    @(posedge clk); #1;

    // Back-to-back: three beats on consecutive cycles.
    beat_cyc.delete();
    send_vec(16'h0003);
    send_vec(16'h0100);
    drain();
    chk(beat_cyc.size() == 3, "b2b_beat_count", beat_cyc.size(), 3);
    if (beat_cyc.size() == 3)
      chk(beat_cyc[2] - beat_cyc[0] == 2, "b2b_consecutive", beat_cyc[2] - beat_cyc[0], 2);

    // Reset mid-scan.
    base = beat_cyc.size();
    send_vec(16'hFFFF);
    begin
      int t = 0;
      while (beat_cyc.size() < base + 4 && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk(t < 100, "rst_scan_timeout", t, 100);
    end
    @(posedge clk); #1;
    rst = 1'b1; ready_force = 0;
    sb.delete();
    @(negedge clk);
    chk(!in_ready, "in_ready_rst_high", int'(in_ready), 0);
    @(negedge clk);
    chk(!out_valid && out_index == 0 && !out_last && !empty_pulse, "rst_mid_scan_outputs",
        int'({out_valid, out_index, out_last, empty_pulse}), 0);
    @(posedge clk); #1;
    rst = 1'b0; ready_force = 1;
    send_vec(16'h0010);
    drain();

    // Randomized traffic with random backpressure and enable.
    rand_ready = 1; rand_en = 1;
    for (int n = 0; n < 150; n++) begin
      case ($urandom % 4)
        0:       v = '0;
        1:       v = W'(1) << ($urandom % W);
        default: v = W'($urandom);
      endcase
      send_vec(v);
      repeat ($urandom % 3) begin
        @(posedge clk); #1;
      end
    end
    rand_en = 0; enable = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
    chk(exp_empty == 0, "empty_pulses_seen", exp_empty, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
